// File: rtl/tcdm_rob.sv
// tcdm_rob: reorder buffer between the core load/store port and the TCDM shim.
// Reads/AMOs get a circular meta ID; responses return to the core in order.
module tcdm_rob #(
    parameter int unsigned DataWidth           = 32,
    parameter int unsigned MaxOutStandingReads = 8,
    localparam int unsigned MetaIdWidth =
        (MaxOutStandingReads > 1) ? $clog2(MaxOutStandingReads) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            core_qaddr_i,
    input  logic                   core_qwrite_i,
    input  logic [3:0]             core_qamo_i,
    input  logic [DataWidth-1:0]   core_qdata_i,
    input  logic [DataWidth/8-1:0] core_qstrb_i,
    input  logic                   core_qvalid_i,
    output logic                   core_qready_o,
    output logic [DataWidth-1:0]   core_pdata_o,
    output logic                   core_perror_o,
    output logic                   core_pvalid_o,
    input  logic                   core_pready_i,
    output logic [31:0]            shim_qaddr_o,
    output logic                   shim_qwrite_o,
    output logic [3:0]             shim_qamo_o,
    output logic [DataWidth-1:0]   shim_qdata_o,
    output logic [DataWidth/8-1:0] shim_qstrb_o,
    output logic [MetaIdWidth-1:0] shim_qid_o,
    output logic                   shim_qvalid_o,
    input  logic                   shim_qready_i,
    input  logic [DataWidth-1:0]   shim_pdata_i,
    input  logic                   shim_perror_i,
    input  logic [MetaIdWidth-1:0] shim_pid_i,
    input  logic                   shim_pvalid_i,
    output logic                   shim_pready_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutStandingReads + 1);
    localparam logic [MetaIdWidth-1:0] LastId =
        MetaIdWidth'(MaxOutStandingReads - 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutStandingReads);

    if (DataWidth != 32) begin : g_bad_data_width
        $fatal(1, "tcdm_rob: only DataWidth = 32 is supported");
    end
    if (MaxOutStandingReads < 2) begin : g_bad_depth
        $fatal(1, "tcdm_rob: MaxOutStandingReads must be >= 2");
    end

    logic [MetaIdWidth-1:0]         head_q, tail_q;
    logic [MetaIdWidth-1:0]         head_next, tail_next;
    logic [CntWidth-1:0]            count_q;
    logic [MaxOutStandingReads-1:0] done_q;
    logic [MaxOutStandingReads-1:0] err_q;
    logic [DataWidth-1:0]           data_q [MaxOutStandingReads];

    logic is_read, full, gate;
    logic do_alloc, do_release;
    int   pid_off;
    logic pid_outstanding;

    // Request path: zero-latency pass-through, reads gated when the ROB is full.
    always_comb begin
        is_read       = !core_qwrite_i;
        full          = (count_q == MaxCnt);
        gate          = is_read & full;
        shim_qvalid_o = core_qvalid_i & !gate;
        core_qready_o = shim_qready_i & !gate;
        shim_qid_o    = is_read ? tail_q : '0;
        shim_qaddr_o  = core_qaddr_i;
        shim_qwrite_o = core_qwrite_i;
        shim_qamo_o   = core_qamo_i;
        shim_qdata_o  = core_qdata_i;
        shim_qstrb_o  = core_qstrb_i;
        shim_pready_o = 1'b1;
    end

    // In-order release from the head entry, plus pointer wrap arithmetic.
    always_comb begin
        core_pvalid_o = (count_q != '0) & done_q[head_q];
        core_pdata_o  = data_q[head_q];
        core_perror_o = err_q[head_q];
        do_alloc      = shim_qvalid_o & shim_qready_i & is_read;
        do_release    = core_pvalid_o & core_pready_i;
        tail_next     = (tail_q == LastId) ? '0 : tail_q + 1'b1;
        head_next     = (head_q == LastId) ? '0 : head_q + 1'b1;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_alloc) tail_q <= tail_next;
            if (do_release) head_q <= head_next;
            case ({do_alloc, do_release})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage: capture by response ID, clear done on release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= '0;
            err_q  <= '0;
            for (int i = 0; i < int'(MaxOutStandingReads); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (do_release) done_q[head_q] <= 1'b0;
            if (shim_pvalid_i) begin
                done_q[shim_pid_i] <= 1'b1;
                err_q[shim_pid_i]  <= shim_perror_i;
                data_q[shim_pid_i] <= shim_pdata_i;
            end
        end
    end

    // Distance of the response ID from head, used to flag stray responses.
    always_comb begin
        if (shim_pid_i >= head_q) begin
            pid_off = int'(shim_pid_i) - int'(head_q);
        end else begin
            pid_off = int'(shim_pid_i) + int'(MaxOutStandingReads)
                      - int'(head_q);
        end
        pid_outstanding = (pid_off < int'(count_q));
    end

    a_count_max: assert property (
        @(posedge clk_i) disable iff (rst_i)
        count_q <= MaxCnt
    );

    a_pdata_stable: assert property (
        @(posedge clk_i) disable iff (rst_i)
        core_pvalid_o && !core_pready_i
        |=> core_pvalid_o && $stable(core_pdata_o)
    );

    a_resp_legal: assert property (
        @(posedge clk_i) disable iff (rst_i)
        shim_pvalid_i |-> pid_outstanding && !done_q[shim_pid_i]
    );

endmodule
